// File: rtl/div_seq_pkg.sv
// Shared constants for the divider request sequencer: default sizes, the state
// encoding and the divide-by-zero quotient pattern.
package div_seq_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMEOUT = DEF_WIDTH + 4;
  localparam int unsigned MAX_WIDTH   = 64;

  // All-ones quotient reported for a zero divisor; sliced to WIDTH at use
  localparam logic [MAX_WIDTH-1:0] DZ_ONES = '1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_OUT  = 2'd2;

endpackage

// File: rtl/div_seq_ctrl.sv
// Sequencer in front of the iterative restoring divider: latches operands, holds
// start through RUN, captures the result. Optional RUN timeout: DIV_SEQ_TIMEOUT_EN.
module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = WIDTH + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dz,
  output logic             out_err
);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH || TIMEOUT < 1) begin : g_param_chk
    $error("div_seq_ctrl: unsupported WIDTH/TIMEOUT");
  end

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_start;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  state_t           w_state_nxt;
  logic             w_load_ops;
  logic             w_load_res;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_r_nxt;
  logic             w_dz_nxt;

`ifdef DIV_SEQ_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  logic [TCW-1:0] r_tcnt;
  logic           r_err;
  logic           w_err_nxt;
`endif

  // Next-state and result-capture decode
  always_comb begin
    w_state_nxt = r_state;
    w_load_ops  = 1'b0;
    w_load_res  = 1'b0;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_dz_nxt    = r_dz;
`ifdef DIV_SEQ_TIMEOUT_EN
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_load_ops = 1'b1;
          if (in_divisor == '0) begin
            w_state_nxt = ST_OUT;
            w_load_res  = 1'b1;
            w_q_nxt     = DZ_ONES[WIDTH-1:0];
            w_r_nxt     = in_dividend;
            w_dz_nxt    = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (r_start && div_done) begin
          w_state_nxt = ST_OUT;
          w_load_res  = 1'b1;
          w_q_nxt     = div_q;
          w_r_nxt     = div_r;
          w_dz_nxt    = 1'b0;
        end
`ifdef DIV_SEQ_TIMEOUT_EN
        else if (r_tcnt == TCW'(TIMEOUT - 1)) begin
          w_state_nxt = ST_OUT;
          w_load_res  = 1'b1;
          w_q_nxt     = '0;
          w_r_nxt     = '0;
          w_dz_nxt    = 1'b0;
          w_err_nxt   = 1'b1;
        end
`endif
      end
      ST_OUT: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags and start are decoded from the next state so they line up with r_state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_start     <= 1'b0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_dz        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_OUT);
      r_start     <= (w_state_nxt == ST_RUN);
      if (w_load_ops) begin
        r_dividend <= in_dividend;
        r_divisor  <= in_divisor;
      end
      if (w_load_res) begin
        r_q  <= w_q_nxt;
        r_r  <= w_r_nxt;
        r_dz <= w_dz_nxt;
      end
    end
  end

`ifdef DIV_SEQ_TIMEOUT_EN
  // RUN-cycle counter: zero on RUN entry, error flag captured with the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_tcnt <= (r_state == ST_RUN) ? r_tcnt + TCW'(1) : '0;
      if (w_load_res) begin
        r_err <= w_err_nxt;
      end
    end
  end

  assign out_err = r_err;
`else
  assign out_err = 1'b0;
`endif

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign div_start    = r_start;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign out_q        = r_q;
  assign out_r        = r_r;
  assign out_dz       = r_dz;

endmodule
